// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM round-robin arbiter.
// Holds the FSM state encoding and the default block widths.
package ram_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_DATA_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR     = 2'd1,
    ST_RD_ISS = 2'd2,
    ST_RD_CAP = 2'd3
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational request picker for the RAM arbiter.
// Default: round-robin, search starts at ptr+1 and wraps modulo NUM_REQ.
// RAM_ARB_FIXED_PRIO_EN defined: lowest set index wins and ptr is ignored.
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  IDX_W    index of the last winner
//   any     out 1        at least one request is set
//   win     out NUM_REQ  one-hot winner (zero when no request)
//   win_idx out IDX_W    binary index of the winner
module rr_picker
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   win_idx
);

  logic found;

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Lowest index wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
    any = found;
    win = found ? (NUM_REQ'(1) << win_idx) : '0;
  end
`else
  logic [IDX_W-1:0] cand;

  // First set bit after ptr, wrapping; ptr itself is checked last.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      cand = IDX_W'((32'(ptr) + 32'(i)) % NUM_REQ);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    any = found;
    win = found ? (NUM_REQ'(1) << win_idx) : '0;
  end
`endif

endmodule

// File: rtl/ram_rr_arbiter.sv
// Shares one dual-port RAM (separate write/read ports) between NUM_REQ
// requesters using a req/gnt handshake and round-robin arbitration.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (lowest wins).
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_i/we_i             per-requester request level and write select
//   addr_i/wdata_i         packed per-requester address / write data
//   gnt_o                  one-hot 1-cycle grant
//   rvalid_o/rdata_o       one-hot 1-cycle read-valid and read data
//   ram_wr_*               RAM write port drive
//   ram_rd_en_o/addr_o     RAM read port drive
//   ram_rd_data_i          RAM read data, valid while ram_rd_en_o is high
module ram_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      ram_wr_en_o,
  output logic [ADDR_W-1:0]         ram_wr_addr_o,
  output logic [DATA_W-1:0]         ram_wr_data_o,
  output logic                      ram_rd_en_o,
  output logic [ADDR_W-1:0]         ram_rd_addr_o,
  input  logic [DATA_W-1:0]         ram_rd_data_i
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win;
  logic               any;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req_i),
    .ptr     (ptr),
    .any     (any),
    .win     (win),
    .win_idx (win_idx)
  );

  // FSM, request latch and registered RAM/client outputs.
  // Pulses and enables default low each cycle; addresses, write data and
  // rdata_o hold until overwritten.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      ptr           <= IDX_W'(NUM_REQ - 1);
      cur_idx       <= '0;
      gnt_o         <= '0;
      rvalid_o      <= '0;
      rdata_o       <= '0;
      ram_wr_en_o   <= 1'b0;
      ram_wr_addr_o <= '0;
      ram_wr_data_o <= '0;
      ram_rd_en_o   <= 1'b0;
      ram_rd_addr_o <= '0;
    end else begin
      gnt_o       <= '0;
      rvalid_o    <= '0;
      ram_wr_en_o <= 1'b0;
      ram_rd_en_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            cur_idx <= win_idx;
            gnt_o   <= win;
`ifndef RAM_ARB_FIXED_PRIO_EN
            ptr     <= win_idx;
`endif
            if (we_i[win_idx]) begin
              ram_wr_en_o   <= 1'b1;
              ram_wr_addr_o <= addr_i[win_idx*ADDR_W +: ADDR_W];
              ram_wr_data_o <= wdata_i[win_idx*DATA_W +: DATA_W];
              state         <= ST_WR;
            end else begin
              ram_rd_en_o   <= 1'b1;
              ram_rd_addr_o <= addr_i[win_idx*ADDR_W +: ADDR_W];
              state         <= ST_RD_ISS;
            end
          end
        end
        ST_WR: begin
          state <= ST_IDLE;
        end
        ST_RD_ISS: begin
          // Keep rd_en high so the RAM output stays driven through capture.
          ram_rd_en_o <= 1'b1;
          state       <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          rdata_o  <= ram_rd_data_i;
          rvalid_o <= NUM_REQ'(1) << cur_idx;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Self-checking bench for ram_rr_arbiter with a 32x256 RAM model.
// A transaction-level model predicts every output per clock edge; directed
// scenarios add literal expectations, then randomized traffic follows.
module tb_ram_rr_arbiter;

  localparam int N    = 4;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            ram_wr_en, ram_rd_en;
  logic [AW-1:0]   ram_wr_addr, ram_rd_addr;
  logic [DW-1:0]   ram_wr_data, ram_rd_data;

  ram_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .ram_wr_en_o(ram_wr_en), .ram_wr_addr_o(ram_wr_addr),
    .ram_wr_data_o(ram_wr_data), .ram_rd_en_o(ram_rd_en),
    .ram_rd_addr_o(ram_rd_addr), .ram_rd_data_i(ram_rd_data)
  );

  // RAM: synchronous write, registered read, output undriven (0) when rd_en low.
  logic [DW-1:0] bram [256];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (ram_wr_en) bram[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_q <= bram[ram_rd_addr];
  end
  assign ram_rd_data = ram_rd_en ? ram_q : '0;

  int checks = 0;
  int failures = 0;
  int ecnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, ecnt);
    end
  endtask

  // Expected outputs after each clock edge, filled in by the model.
  bit [N-1:0]  e_gnt [MAXC];
  bit [N-1:0]  e_rv  [MAXC];
  bit          e_wen [MAXC], e_ren [MAXC], r_clr [MAXC];
  bit          s_wa [MAXC], s_ra [MAXC], s_rd [MAXC];
  bit [AW-1:0] v_wa [MAXC], v_ra [MAXC];
  bit [DW-1:0] v_wd [MAXC], v_rd [MAXC];
  bit [DW-1:0] mmem [256];
  int          free_at = 0;
  int          mptr = N - 1;

  function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef RAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int i = 1; i <= N; i++) if (r[(p + i) % N]) return (p + i) % N;
`endif
    return -1;
  endfunction

  task automatic clr_slot(input int i);
    if (i < MAXC) begin
      e_gnt[i] = '0; e_rv[i] = '0; e_wen[i] = 0; e_ren[i] = 0;
      s_wa[i] = 0; s_ra[i] = 0; s_rd[i] = 0;
    end
  endtask

  // Arbiter model: when free and requests exist, serve the rule's winner.
  // Write occupies 2 cycles, read 3 cycles; read data returns 2 edges after grant.
  always @(posedge clk) begin : model_p
    int e, k;
    logic [AW-1:0] a;
    e = ecnt + 1;
    ecnt = e;
    if (e + 4 < MAXC) begin
      if (rst) begin
        mptr = N - 1;
        free_at = e + 1;
        for (int i = 0; i < 4; i++) clr_slot(e + i);
        r_clr[e] = 1;
      end else if (e >= free_at && req != '0) begin
        k = pick(req, mptr);
`ifndef RAM_ARB_FIXED_PRIO_EN
        mptr = k;
`endif
        e_gnt[e][k] = 1'b1;
        a = addr[k*AW +: AW];
        if (we[k]) begin
          e_wen[e] = 1; s_wa[e] = 1; v_wa[e] = a; v_wd[e] = wdata[k*DW +: DW];
          mmem[a] = wdata[k*DW +: DW];
          free_at = e + 2;
        end else begin
          e_ren[e] = 1; e_ren[e+1] = 1; s_ra[e] = 1; v_ra[e] = a;
          e_rv[e+2][k] = 1'b1; s_rd[e+2] = 1; v_rd[e+2] = mmem[a];
          free_at = e + 3;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  bit [AW-1:0] m_wa, m_ra;
  bit [DW-1:0] m_wd, m_rd;
  always @(negedge clk) begin : cmp_p
    int e;
    e = ecnt;
    if (e >= 1 && e < MAXC) begin
      if (r_clr[e]) begin m_wa = '0; m_wd = '0; m_ra = '0; m_rd = '0; end
      if (s_wa[e]) begin m_wa = v_wa[e]; m_wd = v_wd[e]; end
      if (s_ra[e]) m_ra = v_ra[e];
      if (s_rd[e]) m_rd = v_rd[e];
      chk("m_gnt", 32'(gnt), 32'(e_gnt[e]));
      chk("m_rvalid", 32'(rvalid), 32'(e_rv[e]));
      chk("m_wr_en", 32'(ram_wr_en), 32'(e_wen[e]));
      chk("m_rd_en", 32'(ram_rd_en), 32'(e_ren[e]));
      chk("m_wr_addr", 32'(ram_wr_addr), 32'(m_wa));
      chk("m_wr_data", ram_wr_data, m_wd);
      chk("m_rd_addr", 32'(ram_rd_addr), 32'(m_ra));
      chk("m_rdata", rdata, m_rd);
    end
  end

  task automatic drive(input int k, input bit r, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    req[k] = r;
    we[k] = w;
    addr[k*AW +: AW] = a;
    wdata[k*DW +: DW] = d;
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  int exp_ord [5];
  int got_ord [5];
  int ng, guard, npulse, ngnt;
  int pc [2];
  logic [DW-1:0] pd [2];

  initial begin
    for (int i = 0; i < 256; i++) begin bram[i] = '0; mmem[i] = '0; end
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wr_en", 32'(ram_wr_en), 0);
    chk("rst_rd_en", 32'(ram_rd_en), 0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: req0 write 0x10 <- DEADBEEF
    drive(0, 1, 1, 8'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_wr_en", 32'(ram_wr_en), 1);
    chk("t1_wr_addr", 32'(ram_wr_addr), 32'h10);
    chk("t1_wr_data", ram_wr_data, 32'hDEADBEEF);
    req[0] = 1'b0;
    @(negedge clk);
    chk("t1_wr_en_off", 32'(ram_wr_en), 0);
    chk("t1_bram", bram[8'h10], 32'hDEADBEEF);

    // Test 2: req1 read 0x10
    drive(1, 1, 0, 8'h10, '0);
    @(negedge clk);
    chk("t2_gnt", 32'(gnt), 32'h2);
    chk("t2_rd_en", 32'(ram_rd_en), 1);
    req[1] = 1'b0;
    @(negedge clk);
    chk("t2_rvalid_early", 32'(rvalid), 0);
    @(negedge clk);
    chk("t2_rvalid", 32'(rvalid), 32'h2);
    chk("t2_rdata", rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("t2_rvalid_off", 32'(rvalid), 0);

    // Test 3: all requesters writing addr=k, grant order from reset pointer
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N; k++) drive(k, 1, 1, 8'(k), 32'hA0000000 + 32'(k));
`ifdef RAM_ARB_FIXED_PRIO_EN
    exp_ord = '{0, 0, 0, 0, 0};
`else
    exp_ord = '{0, 1, 2, 3, 0};
`endif
    ng = 0; guard = 0;
    while (ng < 5 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (gnt != '0) begin got_ord[ng] = oh2i(gnt); ng++; end
    end
    req = '0;
    chk("t3_grant_count", 32'(ng), 5);
    for (int i = 0; i < ng; i++) chk($sformatf("t3_order%0d", i), 32'(got_ord[i]), 32'(exp_ord[i]));
    repeat (2) @(negedge clk);

    // Test 4: req2 raised and dropped while a read is busy
    drive(0, 1, 0, 8'h00, '0);
    @(negedge clk);
    chk("t4_gnt0", 32'(gnt), 32'h1);
    req[0] = 1'b0;
    drive(2, 1, 1, 8'h55, 32'h55555555);
    @(negedge clk);
    req[2] = 1'b0;
    @(negedge clk);
    chk("t4_rvalid", 32'(rvalid), 32'h1);
    chk("t4_rdata", rdata, 32'hA0000000);
    for (int i = 0; i < 3; i++) begin
      chk("t4_no_gnt", 32'(gnt), 0);
      chk("t4_no_wr", 32'(ram_wr_en), 0);
      @(negedge clk);
    end
    chk("t4_bram55", bram[8'h55], 0);

    // Test 5: reset during RD_CAP drops the read
    drive(1, 1, 0, 8'h10, '0);
    @(negedge clk);
    chk("t5_gnt", 32'(gnt), 32'h2);
    req[1] = 1'b0;
    @(negedge clk);
    chk("t5_rdata_before", rdata, 32'hA0000000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rvalid", 32'(rvalid), 0);
    chk("t5_rdata", rdata, 0);
    chk("t5_gnt_off", 32'(gnt), 0);
    chk("t5_rd_en", 32'(ram_rd_en), 0);
    @(negedge clk);
    chk("t5_rvalid_late", 32'(rvalid), 0);

    // Test 6: req3 back-to-back reads of 0xFF and 0x00
    drive(3, 1, 1, 8'hFF, 32'h12345678);
    @(negedge clk);
    chk("t6_wgnt", 32'(gnt), 32'h8);
    req[3] = 1'b0;
    @(negedge clk);
    drive(3, 1, 0, 8'hFF, '0);
    npulse = 0; ngnt = 0; guard = 0;
    while (npulse < 2 && guard < 30) begin
      @(negedge clk);
      guard++;
      if (gnt[3]) begin
        ngnt++;
        if (ngnt == 1) addr[3*AW +: AW] = 8'h00;
        else req[3] = 1'b0;
      end
      if (rvalid[3]) begin pc[npulse] = guard; pd[npulse] = rdata; npulse++; end
    end
    req = '0;
    chk("t6_pulses", 32'(npulse), 2);
    if (npulse == 2) begin
      chk("t6_data_ff", pd[0], 32'h12345678);
      chk("t6_data_00", pd[1], 32'hA0000000);
      chk("t6_spacing", 32'(pc[1] - pc[0]), 3);
    end
    repeat (3) @(negedge clk);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 2500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < N; k++) begin
        if (req[k]) begin
          if (gnt[k]) begin
            if ($urandom_range(0, 1) == 1)
              drive(k, 1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
            else
              req[k] = 1'b0;
          end else if ($urandom_range(0, 99) == 0) begin
            req[k] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          drive(k, 1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
        end
      end
      @(negedge clk);
    end
    rst = 1'b0;
    req = '0;
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
